dcache_fill_ctrl: RTL
=====================

Name: dcache_fill_ctrl

Overview:
Memory-side engine that drives the flush/fill interface of a data-cache line.
- On a miss it writes back the old line if dirty, word by word, then refills the line from main memory, one word per beat.
- It drives flush_mode, flush_write, flush_addr, line_in, line_in_valid and flush_dirty into the line, and its memory port into the bus arbiter.
- One instance serves the whole cache; the cache top routes its line strobes to the selected line.

Parameters:
DATABITS, 32, data word width
ADDRBITS, 32, byte address width
CACHEADDRBITS, 5, word index bits per line
LSBITS, 2, byte-offset bits
CACHESIZE, 2**CACHEADDRBITS, words per line

Ports:
clk  in  1  clock, rising edge; the only clock
reset_n  in  1  asynchronous, active-low reset
fill_req  in  1  start request, level; sampled in IDLE only
fill_addr  in  ADDRBITS  missing address; captured on accept
fill_dirty_in  in  1  line currently dirty; write-back needed; captured on accept
fill_wr_in  in  1  miss caused by a write; captured on accept
wb_base_addr  in  ADDRBITS  memory base of the old line contents; captured on accept
line_data  in  DATABITS  line read data, valid 1 cycle after flush_addr
busy  out  1  engine active, not IDLE
fill_done  out  1  1-cycle pulse when the refill completes
flush_mode  out  1  line in flush mode, high from accept until DONE
flush_write  out  1  write strobe into the line
flush_addr  out  CACHEADDRBITS  word index in the line
flush_dirty  out  1  captured fill_wr_in, held during the fill
line_in  out  DATABITS  refill data word
line_in_valid  out  1  qualifies line_in; same cycle as flush_write
mem_addr  out  ADDRBITS  word-aligned memory address
mem_rdreq  out  1  read request, held until mem_ready
mem_wrreq  out  1  write request, held until mem_ready
mem_wrdata  out  DATABITS  write-back data
mem_ready  in  1  request accepted this cycle
mem_rddata  in  DATABITS  read data
mem_rdvalid  in  1  read data valid

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state IDLE; every output 0; word counter 0; captured registers 0.
- IDLE:
  - On fill_req=1, capture fill_addr, fill_dirty_in, fill_wr_in and wb_base_addr, clear the counter, set busy and flush_mode.
  - Go to WB_ADDR if the captured dirty flag is 1, else FILL_REQ.
- WB_ADDR: flush_addr=cnt; next cycle go to WB_WRITE.
- WB_WRITE:
  - Drive mem_wrreq=1, mem_addr=wb_base_addr+(cnt<<LSBITS), mem_wrdata=line_data (registered at entry).
  - Hold all three stable until mem_ready=1.
  - Then, if cnt==CACHESIZE-1: cnt<=0 and go to FILL_REQ; else cnt+1 and go to WB_ADDR.
- FILL_REQ:
  - Drive mem_rdreq=1, mem_addr={fill_addr[ADDRBITS-1:CACHEADDRBITS+LSBITS], cnt, LSBITS'b0}.
  - On mem_ready go to FILL_WAIT.
- FILL_WAIT:
  - On mem_rdvalid, for 1 cycle: line_in=mem_rddata, line_in_valid=1, flush_write=1, flush_addr=cnt.
  - Then, if cnt==CACHESIZE-1 go to DONE, else cnt+1 and go to FILL_REQ.
- DONE:
  - fill_done=1 for 1 cycle; flush_mode=0 and busy=0 in the same cycle; return to IDLE.
  - fill_req sampled again from the next cycle.
- Outstanding reads: at most one; the next read is never issued before the current one's rdvalid.
- mem_rdvalid outside FILL_WAIT is ignored.
- mem_ready with no request is ignored.
- mem_ready and mem_rdvalid in the same FILL_REQ cycle: rdvalid is ignored; the memory must return data no earlier than the cycle after ready.
- fill_req while busy: ignored; no queueing.
- Counter: CACHEADDRBITS wide; wraps only at the phase end; never exceeds CACHESIZE-1.
- Address arithmetic is modulo 2**ADDRBITS. wb_base_addr is assumed line-aligned; its low CACHEADDRBITS+LSBITS bits are ignored (forced 0).
- flush_dirty follows captured fill_wr_in from accept through DONE; 0 in IDLE.
- Latency, clean miss with zero-wait memory: 1 + CACHESIZE*(2+memlat) + 1 cycles.

Decomposition:
- Package dcache_pkg:
  - state encoding constants ST_IDLE, ST_WB_ADDR, ST_WB_WRITE, ST_FILL_REQ, ST_FILL_WAIT, ST_DONE;
  - shared DATABITS/ADDRBITS/CACHEADDRBITS/LSBITS defaults.
- One natural sub-module: dcache_fill_addrgen (counter plus base/index concatenation producing mem_addr and flush_addr).
- The FSM stays in the top.

Test Plan:
1. Clean miss, fill_addr=0x0000_1234, memory returns word i = 0xA500_0000+i at latency 2 -> 32 mem reads at 0x1200..0x127C; flush_write at flush_addr 0..31 with line_in 0xA500_0000..0xA500_001F; one fill_done; mem_wrreq never asserted.
2. Dirty miss, wb_base_addr=0x0000_8000, line_data = 0xC0DE_0000+index -> 32 writes at 0x8000..0x807C carrying those values, strictly before the first mem_rdreq; then refill as in test 1.
3. mem_ready held low 5 cycles on write 3 -> mem_addr/mem_wrdata/mem_wrreq stable all 5 cycles; no counter advance.
4. fill_req re-pulsed mid-fill plus spurious mem_rdvalid in FILL_REQ -> no restart, no extra flush_write, exactly 32 strobes.
5. reset_n low during FILL_WAIT word 10 -> all outputs 0 asynchronously; after release busy=0; a new fill_req completes a full fill from word 0.
6. fill_wr_in=1 at accept -> flush_dirty=1 through DONE, 0 afterwards; with fill_addr=0xFFFF_FFFC the address generator yields 0xFFFF_FF80..0xFFFF_FFFC with no overflow.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared defaults and state encoding for the data-cache line fill/flush engine.
package dcache_pkg;

  localparam int DATABITS_D      = 32;
  localparam int ADDRBITS_D      = 32;
  localparam int CACHEADDRBITS_D = 5;
  localparam int LSBITS_D        = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WB_ADDR   = 3'd1,
    ST_WB_WRITE  = 3'd2,
    ST_FILL_REQ  = 3'd3,
    ST_FILL_WAIT = 3'd4,
    ST_DONE      = 3'd5
  } fill_state_t;

endpackage

// File: rtl/dcache_fill_addrgen.sv
// Word counter for one line plus memory address formation for write-back and refill.
module dcache_fill_addrgen
  import dcache_pkg::*;
#(
  parameter int ADDRBITS      = ADDRBITS_D,
  parameter int CACHEADDRBITS = CACHEADDRBITS_D,
  parameter int LSBITS        = LSBITS_D,
  parameter int CACHESIZE     = 2**CACHEADDRBITS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cnt_clr,
  input  logic                     cnt_inc,
  input  logic                     wb_phase,
  input  logic [ADDRBITS-1:0]      fill_addr_q,
  input  logic [ADDRBITS-1:0]      wb_base_q,
  output logic [CACHEADDRBITS-1:0] cnt,
  output logic                     cnt_last,
  output logic [ADDRBITS-1:0]      addr
);

  // Clears the word-index and byte-offset bits of an address.
  localparam logic [ADDRBITS-1:0] LINE_MASK =
    ~((ADDRBITS'(1) << (CACHEADDRBITS + LSBITS)) - ADDRBITS'(1));

  logic [ADDRBITS-1:0] offset;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_inc) begin
      cnt <= cnt + CACHEADDRBITS'(1);
    end
  end

  always_comb begin
    cnt_last = (cnt == CACHEADDRBITS'(CACHESIZE - 1));
    offset   = ADDRBITS'(cnt) << LSBITS;
    // Write-back adds modulo 2**ADDRBITS; refill concatenates tag and index.
    if (wb_phase) begin
      addr = (wb_base_q & LINE_MASK) + offset;
    end else begin
      addr = (fill_addr_q & LINE_MASK) | offset;
    end
  end

endmodule

// File: rtl/dcache_fill_ctrl.sv
// Miss engine: writes back a dirty line word by word, then refills it from memory.
module dcache_fill_ctrl
  import dcache_pkg::*;
#(
  parameter int DATABITS      = DATABITS_D,
  parameter int ADDRBITS      = ADDRBITS_D,
  parameter int CACHEADDRBITS = CACHEADDRBITS_D,
  parameter int LSBITS        = LSBITS_D,
  parameter int CACHESIZE     = 2**CACHEADDRBITS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fill_req,
  input  logic [ADDRBITS-1:0]      fill_addr,
  input  logic                     fill_dirty_in,
  input  logic                     fill_wr_in,
  input  logic [ADDRBITS-1:0]      wb_base_addr,
  input  logic [DATABITS-1:0]      line_data,
  output logic                     busy,
  output logic                     fill_done,
  output logic                     flush_mode,
  output logic                     flush_write,
  output logic [CACHEADDRBITS-1:0] flush_addr,
  output logic                     flush_dirty,
  output logic [DATABITS-1:0]      line_in,
  output logic                     line_in_valid,
  output logic [ADDRBITS-1:0]      mem_addr,
  output logic                     mem_rdreq,
  output logic                     mem_wrreq,
  output logic [DATABITS-1:0]      mem_wrdata,
  input  logic                     mem_ready,
  input  logic [DATABITS-1:0]      mem_rddata,
  input  logic                     mem_rdvalid
);

  fill_state_t state, state_nx;

  logic [ADDRBITS-1:0]      fill_addr_q;
  logic [ADDRBITS-1:0]      wb_base_q;
  logic                     wr_q;
  logic [DATABITS-1:0]      wrdata_q;
  logic                     wb_first;
  logic                     capture;
  logic                     cnt_clr;
  logic                     cnt_inc;
  logic                     cnt_last;
  logic [CACHEADDRBITS-1:0] cnt;
  logic [ADDRBITS-1:0]      gen_addr;
  logic                     fill_beat;

  dcache_fill_addrgen #(
    .ADDRBITS      (ADDRBITS),
    .CACHEADDRBITS (CACHEADDRBITS),
    .LSBITS        (LSBITS),
    .CACHESIZE     (CACHESIZE)
  ) u_addrgen (
    .clk         (clk),
    .reset_n     (reset_n),
    .cnt_clr     (cnt_clr),
    .cnt_inc     (cnt_inc),
    .wb_phase    (mem_wrreq),
    .fill_addr_q (fill_addr_q),
    .wb_base_q   (wb_base_q),
    .cnt         (cnt),
    .cnt_last    (cnt_last),
    .addr        (gen_addr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      fill_addr_q <= '0;
      wb_base_q   <= '0;
      wr_q        <= 1'b0;
      wrdata_q    <= '0;
      wb_first    <= 1'b0;
    end else begin
      state    <= state_nx;
      wb_first <= (state != ST_WB_WRITE) && (state_nx == ST_WB_WRITE);
      if (capture) begin
        fill_addr_q <= fill_addr;
        wb_base_q   <= wb_base_addr;
        wr_q        <= fill_wr_in;
      end
      // Line read data arrives in the first WB_WRITE cycle; hold it until mem_ready.
      if (state == ST_WB_WRITE && wb_first) begin
        wrdata_q <= line_data;
      end
    end
  end

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fill_req) begin
          capture  = 1'b1;
          cnt_clr  = 1'b1;
          state_nx = fill_dirty_in ? ST_WB_ADDR : ST_FILL_REQ;
        end
      end
      ST_WB_ADDR: state_nx = ST_WB_WRITE;
      ST_WB_WRITE: begin
        if (mem_ready) begin
          if (cnt_last) begin
            cnt_clr  = 1'b1;
            state_nx = ST_FILL_REQ;
          end else begin
            cnt_inc  = 1'b1;
            state_nx = ST_WB_ADDR;
          end
        end
      end
      ST_FILL_REQ: begin
        if (mem_ready) state_nx = ST_FILL_WAIT;
      end
      ST_FILL_WAIT: begin
        if (mem_rdvalid) begin
          if (cnt_last) begin
            state_nx = ST_DONE;
          end else begin
            cnt_inc  = 1'b1;
            state_nx = ST_FILL_REQ;
          end
        end
      end
      ST_DONE: begin
        cnt_clr  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // All outputs decode from registered state so an async reset zeroes them at once.
  always_comb begin
    busy          = (state == ST_WB_ADDR) || (state == ST_WB_WRITE) ||
                    (state == ST_FILL_REQ) || (state == ST_FILL_WAIT);
    flush_mode    = busy;
    fill_done     = (state == ST_DONE);
    flush_dirty   = wr_q && (state != ST_IDLE);
    flush_addr    = cnt;
    fill_beat     = (state == ST_FILL_WAIT) && mem_rdvalid;
    flush_write   = fill_beat;
    line_in_valid = fill_beat;
    line_in       = fill_beat ? mem_rddata : '0;
    mem_wrreq     = (state == ST_WB_WRITE);
    mem_rdreq     = (state == ST_FILL_REQ);
    mem_addr      = (mem_wrreq || mem_rdreq) ? gen_addr : '0;
    mem_wrdata    = mem_wrreq ? (wb_first ? line_data : wrdata_q) : '0;
  end

endmodule
